// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake and data bundle for pipelined_barrel_shifter.
// Carry output c exists only when BARREL_SHIFTER_CARRY_EN is defined.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic [SW-1:0]    s;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
`ifdef BARREL_SHIFTER_CARRY_EN
  logic             c;
`endif

  // Operand source / result consumer side.
  modport master (
    output in_valid, d, s, mode, out_ready,
`ifdef BARREL_SHIFTER_CARRY_EN
    input  c,
`endif
    input  in_ready, out_valid, y
  );

  // Shifter side.
  modport slave (
    input  in_valid, d, s, mode, out_ready,
`ifdef BARREL_SHIFTER_CARRY_EN
    output c,
`endif
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit barrel shifter: one registered mux level per shift-amount bit.
// Optional last-shifted-out carry output under `define BARREL_SHIFTER_CARRY_EN.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SW = $clog2(WIDTH),
  localparam int unsigned LEVELS = SW
) (
  input logic                         clk,
  input logic                         rst,
  pipelined_barrel_shifter_if.slave   bus
);

  localparam logic [2:0] ModeSll = 3'b000;
  localparam logic [2:0] ModeSrl = 3'b001;
  localparam logic [2:0] ModeSra = 3'b010;
  localparam logic [2:0] ModeRol = 3'b011;
  localparam logic [2:0] ModeRor = 3'b100;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [2:0] m,
                                                input logic sgn,
                                                input int unsigned n);
    logic [2*WIDTH-1:0] ext;
    ext = {{WIDTH{sgn}}, x} >> n;
    case (m)
      ModeSll: shift_by = x << n;
      ModeSrl: shift_by = x >> n;
      ModeSra: shift_by = ext[WIDTH-1:0];
      ModeRol: shift_by = (x << n) | (x >> (WIDTH - n));
      ModeRor: shift_by = (x >> n) | (x << (WIDTH - n));
      default: shift_by = x;
    endcase
  endfunction

  logic adv;

  // Stage k input views; index 0 is the operand port, k>0 is register bank k-1.
  logic [WIDTH-1:0] stg_data  [LEVELS+1];
  logic             stg_valid [LEVELS+1];
  logic [SW-1:0]    stg_amt   [LEVELS];
  logic [2:0]       stg_mode  [LEVELS];
  logic             stg_sign  [LEVELS];

  logic [WIDTH-1:0] data_d  [LEVELS];
  logic [WIDTH-1:0] data_q  [LEVELS];
  logic             valid_q [LEVELS];
  logic [SW-1:0]    amt_q   [LEVELS];
  logic [2:0]       mode_q  [LEVELS];
  logic             sign_q  [LEVELS];

  assign stg_data[0]  = bus.d;
  assign stg_valid[0] = bus.in_valid;
  assign stg_amt[0]   = bus.s;
  assign stg_mode[0]  = bus.mode;
  assign stg_sign[0]  = bus.d[WIDTH-1];

`ifdef BARREL_SHIFTER_CARRY_EN
  // The last nonzero stage's outgoing bit equals d[WIDTH-s] or d[s-1] of the original operand.
  function automatic logic carry_bit(input logic [WIDTH-1:0] x,
                                     input logic [2:0] m,
                                     input logic prev,
                                     input int unsigned n);
    logic [SW-1:0] lo_idx;
    logic [SW-1:0] hi_idx;
    lo_idx = SW'(n - 1);
    hi_idx = SW'(WIDTH - n);
    case (m)
      ModeSll, ModeRol:          carry_bit = x[hi_idx];
      ModeSrl, ModeSra, ModeRor: carry_bit = x[lo_idx];
      default:                   carry_bit = prev;
    endcase
  endfunction

  logic stg_carry [LEVELS+1];
  logic carry_d   [LEVELS];
  logic carry_q   [LEVELS];

  assign stg_carry[0] = 1'b0;
  assign bus.c        = carry_q[LEVELS-1];
`endif

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int unsigned N = 1 << k;

    assign data_d[k] = stg_amt[k][k] ? shift_by(stg_data[k], stg_mode[k], stg_sign[k], N)
                                     : stg_data[k];
    assign stg_data[k+1]  = data_q[k];
    assign stg_valid[k+1] = valid_q[k];

    if (k + 1 < LEVELS) begin : g_fwd
      assign stg_amt[k+1]  = amt_q[k];
      assign stg_mode[k+1] = mode_q[k];
      assign stg_sign[k+1] = sign_q[k];
    end

`ifdef BARREL_SHIFTER_CARRY_EN
    assign carry_d[k] = stg_amt[k][k] ? carry_bit(stg_data[k], stg_mode[k], stg_carry[k], N)
                                      : stg_carry[k];
    assign stg_carry[k+1] = carry_q[k];
`endif
  end

  // Single global enable: the whole pipe freezes only when the result is blocked.
  assign adv          = !(valid_q[LEVELS-1] && !bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = valid_q[LEVELS-1];
  assign bus.y        = data_q[LEVELS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LEVELS; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
        sign_q[k]  <= 1'b0;
`ifdef BARREL_SHIFTER_CARRY_EN
        carry_q[k] <= 1'b0;
`endif
      end
    end else if (adv) begin
      for (int k = 0; k < LEVELS; k++) begin
        data_q[k]  <= data_d[k];
        valid_q[k] <= stg_valid[k];
        amt_q[k]   <= stg_amt[k];
        mode_q[k]  <= stg_mode[k];
        sign_q[k]  <= stg_sign[k];
`ifdef BARREL_SHIFTER_CARRY_EN
        carry_q[k] <= carry_d[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=8): directed cases plus randomized
// traffic with random backpressure, checked against a whole-amount reference model.
module tb_pipelined_barrel_shifter;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LEVELS = 3;

  typedef struct packed {
    logic [7:0]  y;
    logic        c;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int unsigned pop_cyc[$];
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_y;
  bit          rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: whole shift amount applied at once, bit by bit for rotates.
  function automatic void ref_op(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m,
                                 output logic [7:0] y, output logic c);
    int sh;
    logic [2:0] j;
    sh = int'(s);
    y  = d;
    c  = 1'b0;
    if (sh != 0) begin
      case (m)
        3'd0: begin y = d << sh; j = 3'(WIDTH - sh); c = d[j]; end
        3'd1: begin y = d >> sh; j = 3'(sh - 1); c = d[j]; end
        3'd2: begin y = $unsigned($signed(d) >>> sh); j = 3'(sh - 1); c = d[j]; end
        3'd3: begin
          for (int i = 0; i < WIDTH; i++) begin j = 3'((i + sh) % WIDTH); y[j] = d[i]; end
          j = 3'(WIDTH - sh); c = d[j];
        end
        3'd4: begin
          for (int i = 0; i < WIDTH; i++) begin j = 3'((i + sh) % WIDTH); y[i] = d[j]; end
          j = 3'(sh - 1); c = d[j];
        end
        default: ;
      endcase
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m,
                      input bit directed, input logic [7:0] ey, input logic ec);
    exp_t e;
    logic [7:0] ry;
    logic rc;
    int waited;
    if (directed) begin
      e.y = ey; e.c = ec;
    end else begin
      ref_op(d, s, m, ry, rc);
      e.y = ry; e.c = rc;
    end
    bus.in_valid = 1'b1;
    bus.d = d;
    bus.s = s;
    bus.mode = m;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end else begin
      e.cyc = 32'(cyc);
      last_acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle sampling; a valid&&ready seen here transfers on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_y_stable", 32'(bus.y), 32'(prev_y));
        check("stall_valid_held", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: y=%0h with no outstanding op", bus.y);
        end else begin
          e = exp_q.pop_front();
          check("result_y", 32'(bus.y), 32'(e.y));
`ifdef BARREL_SHIFTER_CARRY_EN
          check("result_c", 32'(bus.c), 32'(e.c));
`endif
        end
        pop_cyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y = bus.y;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.d = '0;
    bus.s = '0;
    bus.mode = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_y", 32'(bus.y), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ROL by 3 with latency check.
    pop_cyc.delete();
    send(8'b1101_0011, 3'd3, 3'd3, 1'b1, 8'b1001_1110, 1'b0);
    drain();
    check("rol_count", 32'(pop_cyc.size()), 32'd1);
    if (pop_cyc.size() >= 1) check("rol_latency", 32'(pop_cyc[0] - last_acc), 32'(LEVELS));

    // SRA then SRL back to back: no bubble between results.
    pop_cyc.delete();
    send(8'b1001_0000, 3'd2, 3'd2, 1'b1, 8'b1110_0100, 1'b0);
    send(8'b1001_0000, 3'd2, 3'd1, 1'b1, 8'b0010_0100, 1'b0);
    drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() >= 2) check("b2b_gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);

    // SLL and ROR by 1, both shifting out a 1.
    send(8'b1000_0001, 3'd1, 3'd0, 1'b1, 8'b0000_0010, 1'b1);
    send(8'b1000_0001, 3'd1, 3'd4, 1'b1, 8'b1100_0000, 1'b1);
    drain();

    // s=0 in every shift mode, plus pass-through with nonzero s.
    for (int m = 0; m < 5; m++) send(8'hA5, 3'd0, 3'(m), 1'b1, 8'hA5, 1'b0);
    send(8'hA5, 3'd5, 3'b111, 1'b1, 8'hA5, 1'b0);
    drain();

    // Backpressure: 4 ops streamed while the consumer stalls 5 cycles.
    pop_cyc.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'h3C, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0);
        send(8'hC3, 3'd2, 3'd2, 1'b0, 8'h00, 1'b0);
        send(8'h96, 3'd5, 3'd3, 1'b0, 8'h00, 1'b0);
        send(8'h69, 3'd7, 3'd4, 1'b0, 8'h00, 1'b0);
      end
      begin
        int w;
        w = 0;
        while (!bus.out_valid && w < 50) begin @(posedge clk); w++; end
        check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(pop_cyc.size()), 32'd4);

    // Reset with operations in flight.
    send(8'h81, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0);
    send(8'h42, 3'd2, 3'd1, 1'b0, 8'h00, 1'b0);
    send(8'hF0, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_y", 32'(bus.y), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef BARREL_SHIFTER_CARRY_EN
    check("midrst_c", 32'(bus.c), 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pop_cyc.delete();
    send(8'h0F, 3'd4, 3'd1, 1'b1, 8'h00, 1'b1);
    drain();
    check("post_rst_count", 32'(pop_cyc.size()), 32'd1);
    if (pop_cyc.size() >= 1) check("post_rst_latency", 32'(pop_cyc[0] - last_acc), 32'(LEVELS));

    // Randomized traffic with random backpressure and input gaps.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom), 3'($urandom), 3'($urandom_range(0, 7)), 1'b0, 8'h00, 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter. Generalises the fixed 4-bit rotate to WIDTH bits and five shift/rotate modes.
- One mux level per shift-amount bit, with a register after every level.
- Valid/ready handshake with backpressure.
- Sits between the operand source and the ALU result mux; sustains one operation per cycle.

Parameters:
WIDTH, 8, data width in bits; power of two, minimum 4.
SW, $clog2(WIDTH), shift-amount width (derived; do not override).
LEVELS, SW, number of mux levels, each registered; equals pipeline latency in cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input operation valid
in_ready  output  1  shifter can accept an operation this cycle
d  input  WIDTH  operand
s  input  SW  shift amount, 0..WIDTH-1
mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  result

Behaviour:
- Reset: asynchronous and active-high on rst.
  - All stage valid bits clear; all stage data, amount and mode registers clear to 0.
  - Outputs: out_valid=0, y=0, in_ready=1 while rst is high.
- Global advance enable adv = !(out_valid && !out_ready). in_ready = adv.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - When adv=0, every stage holds its data, valid and mode.
- Pipeline:
  - Stage k (k=0..LEVELS-1) applies a shift of 2^k when bit k of the carried amount is 1.
  - Stage k carries its data, remaining amount and mode to the next stage.
  - The last stage drives y/out_valid directly from its registers.
  - Latency = LEVELS cycles from input transfer to out_valid (3 for WIDTH=8).
  - Throughput = 1 operation per cycle when out_ready=1.
- Arithmetic:
  - SLL/SRL fill with 0.
  - SRA fills with d[WIDTH-1], the original sign, carried through all stages.
  - ROL/ROR wrap bits around modulo WIDTH.
  - s=0 returns d unchanged in every mode.
  - Pass-through modes return d regardless of s.
- Bubbles: an invalid slot propagates as a bubble and its data is don't-care. y holds its last value while out_valid=0 and is not required to clear.
- Simultaneous events:
  - Input and output transfer in the same cycle are allowed when out_ready=1; no bubble is inserted.
  - in_valid=0 with adv=1 shifts a bubble in.
- Reset mid-operation: all in-flight operations are discarded. After rst deasserts, the first accepted operation emerges exactly LEVELS cycles later.
- Inputs d, s and mode are sampled only on input transfer.

Optional Feature:
Macro: BARREL_SHIFTER_CARRY_EN
- Defined:
  - Adds output port c (1 bit), pipelined alongside y with the same latency and valid; resets to 0.
  - c = last bit shifted out:
    - SLL/ROL: d[WIDTH-s].
    - SRL/SRA/ROR: d[s-1].
    - s=0 or pass-through: 0.
- Undefined: port c and its registers do not exist; all other behaviour is identical.

Test Plan:
1. WIDTH=8, out_ready=1; d=8'b1101_0011, mode=ROL, s=3 -> after 3 cycles out_valid=1, y=8'b1001_1110 (c=0 with carry enabled).
2. d=8'b1001_0000, s=2, back-to-back mode=SRA then mode=SRL -> consecutive cycles y=8'b1110_0100 then y=8'b0010_0100; no bubble between them.
3. d=8'b1000_0001, s=1, mode=SLL then mode=ROR -> y=8'b0000_0010 (c=1), then y=8'b1100_0000 (c=1).
4. Backpressure: stream 4 ops, hold out_ready=0 for 5 cycles.
   - in_ready=0 and y/out_valid stable while stalled.
   - After release, all 4 results appear in order with none lost or duplicated.
5. s=0 in all five modes plus mode=3'b111 with s=5, d=8'hA5 -> y=8'hA5 every time.
6. Reset mid-stream: 3 ops in flight, pulse rst between clock edges.
   - out_valid=0 and y=0 immediately.
   - After release, one op with d=8'h0F, mode=SRL, s=4 -> y=8'h00 exactly 3 cycles after acceptance.
